// File: rtl/fairy_sram_arbiter.sv
// Two-requester (instruction/data) arbiter in front of a single SRAM port.
// Data wins by default; a saturating starvation counter forces an instruction grant.
module fairy_sram_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        aclk,
    input  logic        areset,

    input  logic [3:0]  inst_sram_cen,
    input  logic        inst_sram_wr,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic        inst_sram_ack,
    output logic        inst_sram_rrdy,
    output logic [31:0] inst_sram_rdata,

    input  logic [3:0]  data_sram_cen,
    input  logic        data_sram_wr,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic        data_sram_ack,
    output logic        data_sram_rrdy,
    output logic [31:0] data_sram_rdata,

    output logic [3:0]  mem_cen,
    output logic        mem_wr,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        mem_rrdy,
    input  logic [31:0] mem_rdata
);

    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] STARVE_ONE = SW'(32'd1);
    localparam logic [SW-1:0] STARVE_ZERO = SW'(32'd0);
    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } state_t;

    state_t        state_r;
    logic          owner_r;
    logic [SW-1:0] starve_r;
    logic [3:0]    mem_cen_r;
    logic          mem_wr_r;
    logic [31:0]   mem_addr_r;
    logic [31:0]   mem_wdata_r;
    logic          inst_rrdy_r;
    logic          data_rrdy_r;
    logic [31:0]   inst_rdata_r;
    logic [31:0]   data_rdata_r;

    logic          inst_pend_s;
    logic          data_pend_s;
    logic          grant_inst_s;
    logic          inst_ack_s;
    logic          data_ack_s;
    logic          read_done_s;

    // Request decode and winner selection for the IDLE cycle.
    always_comb begin
        inst_pend_s = (inst_sram_cen != 4'hF);
        data_pend_s = (data_sram_cen != 4'hF);
        if (inst_pend_s && (!data_pend_s || (starve_r == STARVE_MAX))) begin
            grant_inst_s = 1'b1;
        end else begin
            grant_inst_s = 1'b0;
        end
    end

    // Memory accept is forwarded to the owner only while the request is on the bus.
    always_comb begin
        inst_ack_s  = 1'b0;
        data_ack_s  = 1'b0;
        read_done_s = 1'b0;
        if (state_r == ST_ISSUE) begin
            if (owner_r == OWNER_DATA) begin
                data_ack_s = mem_ack;
            end else begin
                inst_ack_s = mem_ack;
            end
            read_done_s = mem_ack & ~mem_wr_r & mem_rrdy;
        end else if (state_r == ST_WAIT_RD) begin
            read_done_s = mem_rrdy;
        end else begin
            read_done_s = 1'b0;
        end
    end

    // Transaction FSM, starvation counter, bus registers and read-return registers.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r      <= ST_IDLE;
            owner_r      <= OWNER_INST;
            starve_r     <= STARVE_ZERO;
            mem_cen_r    <= 4'hF;
            mem_wr_r     <= 1'b0;
            mem_addr_r   <= 32'h0000_0000;
            mem_wdata_r  <= 32'h0000_0000;
            inst_rrdy_r  <= 1'b0;
            data_rrdy_r  <= 1'b0;
            inst_rdata_r <= 32'h0000_0000;
            data_rdata_r <= 32'h0000_0000;
        end else begin
            inst_rrdy_r <= 1'b0;
            data_rrdy_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (inst_pend_s || data_pend_s) begin
                        state_r <= ST_ISSUE;
                        if (grant_inst_s) begin
                            owner_r     <= OWNER_INST;
                            starve_r    <= STARVE_ZERO;
                            mem_cen_r   <= inst_sram_cen;
                            mem_wr_r    <= inst_sram_wr;
                            mem_addr_r  <= inst_sram_addr;
                            mem_wdata_r <= inst_sram_wdata;
                        end else begin
                            owner_r     <= OWNER_DATA;
                            mem_cen_r   <= data_sram_cen;
                            mem_wr_r    <= data_sram_wr;
                            mem_addr_r  <= data_sram_addr;
                            mem_wdata_r <= data_sram_wdata;
                            // Only a data grant that bypasses a waiting inst request counts.
                            if (!inst_pend_s) begin
                                starve_r <= STARVE_ZERO;
                            end else if (starve_r != STARVE_MAX) begin
                                starve_r <= starve_r + STARVE_ONE;
                            end else begin
                                starve_r <= starve_r;
                            end
                        end
                    end
                end
                ST_ISSUE: begin
                    if (mem_ack) begin
                        mem_cen_r <= 4'hF;
                        if (mem_wr_r || mem_rrdy) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= ST_WAIT_RD;
                        end
                    end
                end
                ST_WAIT_RD: begin
                    if (mem_rrdy) begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    mem_cen_r <= 4'hF;
                end
            endcase
            if (read_done_s) begin
                if (owner_r == OWNER_DATA) begin
                    data_rrdy_r  <= 1'b1;
                    data_rdata_r <= mem_rdata;
                end else begin
                    inst_rrdy_r  <= 1'b1;
                    inst_rdata_r <= mem_rdata;
                end
            end
        end
    end

    assign mem_cen         = mem_cen_r;
    assign mem_wr          = mem_wr_r;
    assign mem_addr        = mem_addr_r;
    assign mem_wdata       = mem_wdata_r;
    assign inst_sram_ack   = inst_ack_s;
    assign data_sram_ack   = data_ack_s;
    assign inst_sram_rrdy  = inst_rrdy_r;
    assign data_sram_rrdy  = data_rrdy_r;
    assign inst_sram_rdata = inst_rdata_r;
    assign data_sram_rdata = data_rdata_r;

endmodule
